// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock-divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_t;

  localparam int unsigned DIV_MIN = 2;
  localparam int unsigned DIV_DEF = 10;

endpackage

// File: rtl/clk_div_core.sv
// Period counter with registered clk_div/tick; load_i starts a fresh period at load_div_i.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = DIV_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_div_i,
  output logic             last_o,
  output logic             clk_div_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;

  assign last_o = (cnt_q == div_q - 1'b1);

  // Outputs are computed from the next count so they stay aligned with cnt_q.
  always_comb begin
    cnt_d     = '0;
    div_d     = div_q;
    clk_div_d = 1'b0;
    tick_d    = 1'b0;
    if (load_i) begin
      div_d     = load_div_i;
      clk_div_d = 1'b1;
      tick_d    = 1'b1;
    end else if (en_i) begin
      cnt_d     = last_o ? '0 : cnt_q + 1'b1;
      clk_div_d = (cnt_d < (div_q >> 1));
      tick_d    = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_q     <= CNT_W'(DEF_DIV);
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_div_o = clk_div_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_sched.sv
// Divider controller: start/stop FSM, ratio handshake and validation, pending-ratio register.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] load_div;
  logic             cfg_err_q, cfg_err_d;
  logic             en, load, last, xfer, cfg_ok;

  assign cfg_ready = (state_q != PEND);
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_div >= CNT_W'(DIV_MIN));

  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    cfg_err_d  = xfer && !cfg_ok;
    en         = 1'b0;
    load       = 1'b0;
    load_div   = cur_div_q;
    unique case (state_q)
      IDLE: begin
        if (xfer && cfg_ok) begin
          cur_div_d = cfg_div;
          load_div  = cfg_div;
        end
        if (run) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        // A ratio accepted on the stopping edge takes effect directly.
        if (last && !run) begin
          state_d = IDLE;
          if (xfer && cfg_ok) cur_div_d = cfg_div;
        end else begin
          en = 1'b1;
          if (xfer && cfg_ok) begin
            pend_div_d = cfg_div;
            state_d    = PEND;
          end
        end
      end
      PEND: begin
        if (last) begin
          cur_div_d = pend_div_q;
          load_div  = pend_div_q;
          if (run) begin
            state_d = RUN;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_div_q  <= CNT_W'(DEF_DIV);
      pend_div_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  clk_div_core #(
    .CNT_W  (CNT_W),
    .DEF_DIV(DEF_DIV)
  ) u_core (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .load_i    (load),
    .load_div_i(load_div),
    .last_o    (last),
    .clk_div_o (clk_div),
    .tick_o    (tick)
  );

  assign cfg_err = cfg_err_q;
  assign busy    = (state_q != IDLE);
  assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Scenario bench for clk_div_sched: per-cycle expectations queued with the stimulus, then popped and compared.
module tb_clk_div_sched;

  logic        clk = 1'b0;
  logic        rst, run, cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready, cfg_err, clk_div, tick, busy;
  logic [15:0] cur_div;

  typedef struct packed {
    logic        busy;
    logic        clk_div;
    logic        tick;
    logic        rdy;
    logic        err;
    logic [15:0] div;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  clk_div_sched #(
    .CNT_W  (16),
    .DEF_DIV(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk_div  (clk_div),
    .tick     (tick),
    .busy     (busy),
    .cur_div  (cur_div)
  );

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.clk_div = clk_div; o.tick = tick;
    o.rdy = cfg_ready; o.err = cfg_err; o.div = cur_div;
    return o;
  endfunction

  // Running at ratio n, count c within the period.
  function automatic obs_t e_run(int unsigned n, int unsigned c, logic rdy);
    obs_t o;
    o.busy = 1'b1; o.clk_div = (c < n / 2); o.tick = (c == 0);
    o.rdy = rdy; o.err = 1'b0; o.div = 16'(n);
    return o;
  endfunction

  function automatic obs_t e_idle(int unsigned d, logic err);
    obs_t o;
    o.busy = 1'b0; o.clk_div = 1'b0; o.tick = 1'b0;
    o.rdy = 1'b1; o.err = err; o.div = 16'(d);
    return o;
  endfunction

  task automatic test_reset();
    obs_t e, got;
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(e_idle(10, 1'b0));
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL reset k=%0d got=%h exp=%h", k, got, e);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_default_run();
    obs_t e, got;
    for (int k = 0; k <= 30; k++) begin
      run = (k < 25);
      exp_q.push_back(k < 30 ? e_run(10, k % 10, 1'b1) : e_idle(10, 1'b0));
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL default_run k=%0d got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_idle_cfg();
    obs_t e, got;
    for (int k = 0; k <= 9; k++) begin
      cfg_valid = (k == 0); cfg_div = 16'd4;
      run = (k >= 1 && k <= 8);
      if (k == 0 || k == 9) exp_q.push_back(e_idle(4, 1'b0));
      else exp_q.push_back(e_run(4, (k - 1) % 4, 1'b1));
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL idle_cfg k=%0d got=%h exp=%h", k, got, e);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reconfig();
    obs_t e, got;
    for (int k = 0; k <= 23; k++) begin
      cfg_valid = (k == 0 || k == 4);
      cfg_div   = (k == 0) ? 16'd10 : 16'd6;
      run       = (k >= 1 && k <= 22);
      if (k == 0)       exp_q.push_back(e_idle(10, 1'b0));
      else if (k <= 3)  exp_q.push_back(e_run(10, k - 1, 1'b1));
      else if (k <= 10) exp_q.push_back(e_run(10, k - 1, 1'b0));
      else if (k <= 22) exp_q.push_back(e_run(6, (k - 11) % 6, 1'b1));
      else              exp_q.push_back(e_idle(6, 1'b0));
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL reconfig k=%0d got=%h exp=%h", k, got, e);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_cfg_err();
    obs_t e, got;
    run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cfg_valid = (k == 0 || k == 2);
      cfg_div   = (k == 0) ? 16'd1 : 16'd0;
      exp_q.push_back(e_idle(6, (k == 0 || k == 2)));
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL cfg_err k=%0d got=%h exp=%h", k, got, e);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_stop();
    obs_t e, got;
    for (int k = 0; k <= 16; k++) begin
      cfg_valid = (k == 0); cfg_div = 16'd5;
      run = (k >= 1 && k <= 7) || (k >= 9 && k <= 12);
      if (k == 0 || k == 16) exp_q.push_back(e_idle(5, 1'b0));
      else exp_q.push_back(e_run(5, (k - 1) % 5, 1'b1));
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL stop k=%0d got=%h exp=%h", k, got, e);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_pend();
    obs_t e, got;
    for (int k = 0; k <= 23; k++) begin
      cfg_valid = (k == 1); cfg_div = 16'd8;
      rst = (k == 2);
      run = (k <= 1) || (k >= 3 && k <= 20);
      if (k == 0)       exp_q.push_back(e_run(5, 0, 1'b1));
      else if (k == 1)  exp_q.push_back(e_run(5, 1, 1'b0));
      else if (k == 2)  exp_q.push_back(e_idle(10, 1'b0));
      else if (k <= 22) exp_q.push_back(e_run(10, (k - 3) % 10, 1'b1));
      else              exp_q.push_back(e_idle(10, 1'b0));
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL reset_pend k=%0d got=%h exp=%h", k, got, e);
      end
    end
    cfg_valid = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    test_reset();
    test_default_run();
    test_idle_cfg();
    test_reconfig();
    test_cfg_err();
    test_stop();
    test_reset_pend();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
